// File: rtl/sram_model_pkg.sv
// sram_model_pkg: shared helpers, latency limits and init FSM type for the SRAM simulation model
package sram_model_pkg;
  localparam int MIN_LAT = 1;
  localparam int MAX_LAT = 4;
  typedef enum logic {CLEAR, READY} init_state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: LATENCY-stage read valid/data pipeline whose output data holds between valid strobes
module sram_rd_pipe import sram_model_pkg::*; #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic [LATENCY-1:0]            r_v;
  logic [LATENCY-1:0][WIDTH-1:0] r_d;
  logic [LATENCY:0]              w_v;
  logic [LATENCY:0][WIDTH-1:0]   w_d;
  if (LATENCY < MIN_LAT || LATENCY > MAX_LAT) begin : g_bad_lat
    $error("LATENCY out of range");
  end
  assign w_v = {r_v, i_valid};
  assign w_d = {r_d, i_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      r_d <= '0;
    end else begin
      r_v <= w_v[LATENCY-1:0];
      r_d <= w_d[LATENCY-1:0];
      if (!w_v[LATENCY-1]) r_d[LATENCY-1] <= r_d[LATENCY-1];
    end
  end
  assign o_valid = r_v[LATENCY-1];
  assign o_data  = r_d[LATENCY-1];
endmodule

// File: rtl/sram_2p_pipe_model.sv
// sram_2p_pipe_model: parametrised 1RW + 1R behavioural SRAM with masked writes, read pipelines and optional zero-init
module sram_2p_pipe_model import sram_model_pkg::*; #(
  parameter int DEPTH     = 512,
  parameter int WIDTH     = 64,
  parameter int GRAN      = 8,
  parameter int LATENCY   = 1,
  parameter bit RDW_NEW   = 1'b0,
  parameter bit INIT_ZERO = 1'b0,
  localparam int ADDR_W   = clog2(DEPTH) > 1 ? clog2(DEPTH) : 1,
  localparam int MASK_W   = WIDTH / GRAN
) (
  input  logic              RW0_clk,
  input  logic              reset,
  output logic              init_busy,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [MASK_W-1:0] RW0_wmask,
  input  logic [WIDTH-1:0]  RW0_wdata,
  output logic [WIDTH-1:0]  RW0_rdata,
  output logic              RW0_rvalid,
  input  logic [ADDR_W-1:0] R1_addr,
  input  logic              R1_en,
  output logic [WIDTH-1:0]  R1_rdata,
  output logic              R1_rvalid
);
  init_state_t       r_state, w_state_nx;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nx;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_acc, w_wr, w_rw_ok, w_r1_ok;
  logic [WIDTH-1:0]  w_rw_old, w_r1_old, w_merged, w_r1_data;
  if (WIDTH % GRAN != 0) begin : g_bad_gran
    $error("WIDTH must be a multiple of GRAN");
  end
  always_ff @(posedge RW0_clk) begin
    if (reset) begin
      r_state <= INIT_ZERO ? CLEAR : READY;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
    end
  end
  always_comb begin
    w_state_nx = (r_state == CLEAR && r_ptr == ADDR_W'(DEPTH - 1)) ? READY : r_state;
    w_ptr_nx   = (r_state == CLEAR) ? r_ptr + 1'b1 : r_ptr;
  end
  assign init_busy = r_state == CLEAR;
  assign w_acc     = !init_busy && !reset;
  assign w_rw_ok   = 32'(RW0_addr) < DEPTH;
  assign w_r1_ok   = 32'(R1_addr) < DEPTH;
  assign w_rw_old  = w_rw_ok ? r_mem[RW0_addr] : '0;
  assign w_r1_old  = w_r1_ok ? r_mem[R1_addr] : '0;
  assign w_wr      = w_acc && RW0_en && RW0_wmode && w_rw_ok;
  always_comb begin
    w_merged = w_rw_old;
    for (int g = 0; g < MASK_W; g++)
      if (RW0_wmask[g]) w_merged[g*GRAN +: GRAN] = RW0_wdata[g*GRAN +: GRAN];
  end
  assign w_r1_data = (RDW_NEW && w_wr && R1_addr == RW0_addr) ? w_merged : w_r1_old;
  always_ff @(posedge RW0_clk) begin
    if (init_busy) r_mem[r_ptr] <= '0;
    else if (w_wr) r_mem[RW0_addr] <= w_merged;
  end
  sram_rd_pipe #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_rw0_pipe (
    .clk     (RW0_clk),
    .rst     (reset),
    .i_valid (w_acc && RW0_en && !RW0_wmode),
    .i_data  (w_rw_old),
    .o_valid (RW0_rvalid),
    .o_data  (RW0_rdata)
  );
  sram_rd_pipe #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_r1_pipe (
    .clk     (RW0_clk),
    .rst     (reset),
    .i_valid (w_acc && R1_en),
    .i_data  (w_r1_data),
    .o_valid (R1_rvalid),
    .o_data  (R1_rdata)
  );
endmodule

// File: tb/tb_sram_2p_pipe_model.sv
// tb_sram_2p_pipe_model: table-driven cycle vectors for a zero-init LATENCY=3 instance and an RDW_NEW LATENCY=1 instance
module tb_sram_2p_pipe_model;
  typedef struct {
    int          sel;
    logic        rst, en, wm;
    logic [2:0]  addr;
    logic [7:0]  mask;
    logic [63:0] wd;
    logic        r1en;
    logic [2:0]  r1a;
    logic        busy, rv;
    logic [63:0] rd;
    logic        r1v;
    logic [63:0] r1d;
  } vec_t;
  localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] H0 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] HA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] HM = 64'h1122_3344_AAAA_AAAA;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'hDEAD_BEEF_CAFE_F00D;
  logic        clk = 1'b0;
  logic        a_rst = 1'b1, a_en = 1'b0, a_wm = 1'b0, a_r1en = 1'b0;
  logic [2:0]  a_addr = '0, a_r1a = '0;
  logic [7:0]  a_mask = '0;
  logic [63:0] a_wd = '0, a_rd, a_r1d;
  logic        a_busy, a_rv, a_r1v;
  logic        b_rst = 1'b1, b_en = 1'b0, b_wm = 1'b0, b_r1en = 1'b0;
  logic [2:0]  b_addr = '0, b_r1a = '0;
  logic [1:0]  b_mask = '0;
  logic [7:0]  b_wd = '0, b_rd, b_r1d;
  logic        b_busy, b_rv, b_r1v;
  vec_t        tv[$];
  int          cur_sel = 0;
  int          n_vec = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  sram_2p_pipe_model #(.DEPTH(6), .WIDTH(64), .GRAN(8), .LATENCY(3), .RDW_NEW(1'b0), .INIT_ZERO(1'b1)) u_a (
    .RW0_clk(clk), .reset(a_rst), .init_busy(a_busy),
    .RW0_addr(a_addr), .RW0_en(a_en), .RW0_wmode(a_wm), .RW0_wmask(a_mask), .RW0_wdata(a_wd),
    .RW0_rdata(a_rd), .RW0_rvalid(a_rv),
    .R1_addr(a_r1a), .R1_en(a_r1en), .R1_rdata(a_r1d), .R1_rvalid(a_r1v)
  );
  sram_2p_pipe_model #(.DEPTH(8), .WIDTH(8), .GRAN(4), .LATENCY(1), .RDW_NEW(1'b1), .INIT_ZERO(1'b0)) u_b (
    .RW0_clk(clk), .reset(b_rst), .init_busy(b_busy),
    .RW0_addr(b_addr), .RW0_en(b_en), .RW0_wmode(b_wm), .RW0_wmask(b_mask), .RW0_wdata(b_wd),
    .RW0_rdata(b_rd), .RW0_rvalid(b_rv),
    .R1_addr(b_r1a), .R1_en(b_r1en), .R1_rdata(b_r1d), .R1_rvalid(b_r1v)
  );
  task automatic add(input int rst, en, wm, a, m, input logic [63:0] wd, input int r1en, r1a,
                     input int busy, rv, input logic [63:0] rd, input int r1v, input logic [63:0] r1d);
    tv.push_back('{cur_sel, 1'(rst), 1'(en), 1'(wm), 3'(a), 8'(m), wd, 1'(r1en), 3'(r1a),
                   1'(busy), 1'(rv), rd, 1'(r1v), r1d});
  endtask
  task automatic idle(input int busy, rv, input logic [63:0] rd, input int r1v, input logic [63:0] r1d);
    add(0, 0, 0, 0, 0, 64'h0, 0, 0, busy, rv, rd, r1v, r1d);
  endtask
  task automatic chk(input int idx, input string nm, input logic [63:0] got, input logic [63:0] exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, nm, got, exp);
    end
  endtask
  task automatic apply(input vec_t v, input int idx);
    logic        g_busy, g_rv, g_r1v;
    logic [63:0] g_rd, g_r1d;
    if (v.sel == 0) begin
      a_rst = v.rst; a_en = v.en; a_wm = v.wm; a_addr = v.addr; a_mask = v.mask;
      a_wd = v.wd; a_r1en = v.r1en; a_r1a = v.r1a;
    end else begin
      b_rst = v.rst; b_en = v.en; b_wm = v.wm; b_addr = v.addr; b_mask = v.mask[1:0];
      b_wd = v.wd[7:0]; b_r1en = v.r1en; b_r1a = v.r1a;
    end
    @(posedge clk);
    #1;
    n_vec++;
    g_busy = (v.sel == 0) ? a_busy : b_busy;
    g_rv   = (v.sel == 0) ? a_rv : b_rv;
    g_r1v  = (v.sel == 0) ? a_r1v : b_r1v;
    g_rd   = (v.sel == 0) ? a_rd : {56'h0, b_rd};
    g_r1d  = (v.sel == 0) ? a_r1d : {56'h0, b_r1d};
    chk(idx, "init_busy", 64'(g_busy), 64'(v.busy));
    chk(idx, "RW0_rvalid", 64'(g_rv), 64'(v.rv));
    chk(idx, "RW0_rdata", g_rd, v.rd);
    chk(idx, "R1_rvalid", 64'(g_r1v), 64'(v.r1v));
    chk(idx, "R1_rdata", g_r1d, v.r1d);
  endtask
  initial begin
    cur_sel = 0;
    add(1, 0, 0, 0, 0, 64'h0, 0, 0, 1, 0, 64'h0, 0, 64'h0);
    for (int k = 0; k < 5; k++) idle(1, 0, 64'h0, 0, 64'h0);
    idle(0, 0, 64'h0, 0, 64'h0);
    for (int k = 0; k < 6; k++) add(0, 1, 1, k, 'hFF, FF, 0, 0, 0, 0, 64'h0, 0, 64'h0);
    add(1, 0, 0, 0, 0, 64'h0, 0, 0, 1, 0, 64'h0, 0, 64'h0);
    for (int k = 0; k < 5; k++) idle(1, 0, 64'h0, 0, 64'h0);
    add(0, 1, 1, 2, 'hFF, 64'h1234, 1, 1, 0, 0, 64'h0, 0, 64'h0);
    for (int k = 0; k < 6; k++) add(0, 1, 0, k, 0, 64'h0, 1, 5 - k, 0, int'(k >= 2), 64'h0, int'(k >= 2), 64'h0);
    for (int k = 0; k < 2; k++) idle(0, 1, 64'h0, 1, 64'h0);
    add(0, 1, 1, 3, 'hFF, H0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
    add(0, 1, 1, 3, 'h0F, HA, 1, 3, 0, 0, 64'h0, 0, 64'h0);
    add(0, 1, 0, 3, 0, 64'h0, 1, 3, 0, 0, 64'h0, 0, 64'h0);
    idle(0, 0, 64'h0, 1, H0);
    idle(0, 1, HM, 1, HM);
    add(0, 1, 1, 0, 'hFF, D0, 0, 0, 0, 0, HM, 0, HM);
    add(0, 1, 1, 1, 'hFF, D1, 0, 0, 0, 0, HM, 0, HM);
    add(0, 1, 1, 2, 'hFF, D2, 0, 0, 0, 0, HM, 0, HM);
    add(0, 1, 0, 0, 0, 64'h0, 0, 0, 0, 0, HM, 0, HM);
    add(0, 1, 0, 1, 0, 64'h0, 0, 0, 0, 0, HM, 0, HM);
    add(0, 1, 0, 2, 0, 64'h0, 0, 0, 0, 1, D0, 0, HM);
    add(0, 1, 1, 2, 'hFF, 64'h0, 0, 0, 0, 1, D1, 0, HM);
    idle(0, 1, D2, 0, HM);
    for (int k = 0; k < 3; k++) idle(0, 0, D2, 0, HM);
    add(0, 1, 1, 6, 'hFF, FF, 0, 0, 0, 0, D2, 0, HM);
    add(0, 1, 0, 6, 0, 64'h0, 1, 7, 0, 0, D2, 0, HM);
    add(0, 1, 0, 0, 0, 64'h0, 1, 1, 0, 0, D2, 0, HM);
    idle(0, 1, 64'h0, 1, 64'h0);
    idle(0, 1, D0, 1, D1);
    for (int k = 0; k < 2; k++) idle(0, 0, D0, 0, D1);
    add(0, 1, 0, 1, 0, 64'h0, 1, 2, 0, 0, D0, 0, D1);
    add(1, 0, 0, 0, 0, 64'h0, 0, 0, 1, 0, 64'h0, 0, 64'h0);
    for (int k = 0; k < 3; k++) idle(1, 0, 64'h0, 0, 64'h0);
    add(1, 0, 0, 0, 0, 64'h0, 0, 0, 1, 0, 64'h0, 0, 64'h0);
    for (int k = 0; k < 5; k++) idle(1, 0, 64'h0, 0, 64'h0);
    idle(0, 0, 64'h0, 0, 64'h0);
    add(0, 1, 0, 3, 0, 64'h0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
    add(0, 1, 0, 0, 0, 64'h0, 1, 2, 0, 0, 64'h0, 0, 64'h0);
    idle(0, 1, 64'h0, 0, 64'h0);
    idle(0, 1, 64'h0, 1, 64'h0);
    idle(0, 0, 64'h0, 0, 64'h0);
    cur_sel = 1;
    add(1, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
    add(0, 1, 1, 7, 3, 64'h09, 0, 0, 0, 0, 64'h0, 0, 64'h0);
    add(0, 1, 1, 7, 3, 64'h05, 1, 7, 0, 0, 64'h0, 1, 64'h05);
    add(0, 0, 0, 0, 0, 64'h0, 1, 7, 0, 0, 64'h0, 1, 64'h05);
    add(0, 1, 1, 7, 1, 64'hA3, 1, 7, 0, 0, 64'h0, 1, 64'h03);
    add(0, 1, 0, 7, 0, 64'h0, 0, 0, 0, 1, 64'h03, 0, 64'h03);
    add(0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 64'h03, 0, 64'h03);
    for (int i = 0; i < tv.size(); i++) apply(tv[i], i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
